// File: rtl/registers_pkg.sv
// registers_pkg
// Shared definitions for the UART register file and the configuration
// sequencer that programs it:
//   - 3-bit register-file addresses (LDVR/UDVR divisor halves, STR, FSR,
//     CTR, ISR)
//   - seq_state_t, the configuration sequencer state encoding
package registers_pkg;

  localparam logic [2:0] LDVR_ADDR = 3'd0;
  localparam logic [2:0] UDVR_ADDR = 3'd1;
  localparam logic [2:0] STR_ADDR  = 3'd2;
  localparam logic [2:0] FSR_ADDR  = 3'd3;
  localparam logic [2:0] CTR_ADDR  = 3'd4;
  localparam logic [2:0] ISR_ADDR  = 3'd5;

  // Explicit encodings keep the state values stable for checkers and
  // waveform decoders.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_IDLE = 4'd1,
    ST_WR_LDVR   = 4'd2,
    ST_WR_UDVR   = 4'd3,
    ST_WR_STR    = 4'd4,
    ST_WR_FSR    = 4'd5,
    ST_WR_CTR    = 4'd6,
    ST_WR_ISR    = 4'd7,
    ST_DONE      = 4'd8
  } seq_state_t;

endpackage

// File: rtl/config_bus_sequencer.sv
// config_bus_sequencer
// Applies a full configuration set (baud divisor plus STR/FSR/CTR/ISR) to
// the register file over its bus.
//
// Flow: a start_i pulse captures the cfg_* inputs. The sequencer then waits,
// for a bounded time, until both the transmitter and the receiver are idle.
// It then issues six back-to-back writes:
//   LDVR, UDVR, STR, FSR, CTR, ISR
// and finally pulses done_o.
//
// Host arbitration: a host request is a level on cpu_read_i/cpu_write_i with
// cpu_address_i/cpu_data_i. While the sequencer is idle, the request goes
// straight through to bus_* in the same cycle, and cpu_wait_o stays low. At
// any other time, cpu_wait_o follows the strobe and the request is not
// forwarded. The host is expected to hold its request until cpu_wait_o is
// low; the access completes in the first cycle where cpu_wait_o is low.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i                       one-cycle request to apply cfg_*
//   cfg_divisor_i                 16-bit baud divisor
//   cfg_{str,fsr,ctr,isr}_i       register bytes
//   tx_idle_i, rx_idle_i          link idle flags
//   cpu_read_i, cpu_write_i       host strobes
//   cpu_address_i, cpu_data_i     host address and write data
//   cpu_wait_o                    host access blocked this cycle
//   bus_read_o, bus_write_o       register-file strobes
//   bus_address_o, bus_data_o     register-file address and write data
//   busy_o                        sequencer owns the bus
//   done_o                        one-cycle pulse: sequence completed
//   timeout_o                     one-cycle pulse: link never went idle
module config_bus_sequencer
  import registers_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] cfg_divisor_i,
  input  logic [7:0]  cfg_str_i,
  input  logic [7:0]  cfg_fsr_i,
  input  logic [7:0]  cfg_ctr_i,
  input  logic [7:0]  cfg_isr_i,
  input  logic        tx_idle_i,
  input  logic        rx_idle_i,
  input  logic        cpu_read_i,
  input  logic        cpu_write_i,
  input  logic [2:0]  cpu_address_i,
  input  logic [7:0]  cpu_data_i,
  output logic        cpu_wait_o,
  output logic        bus_read_o,
  output logic        bus_write_o,
  output logic [2:0]  bus_address_o,
  output logic [7:0]  bus_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  seq_state_t       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [15:0]      div_q,     div_d;
  logic [7:0]       str_q,     str_d;
  logic [7:0]       fsr_q,     fsr_d;
  logic [7:0]       ctr_q,     ctr_d;
  logic [7:0]       isr_q,     isr_d;
  logic             timeout_q, timeout_d;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    str_d     = str_q;
    fsr_d     = fsr_q;
    ctr_d     = ctr_q;
    isr_d     = isr_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          div_d   = cfg_divisor_i;
          str_d   = cfg_str_i;
          fsr_d   = cfg_fsr_i;
          ctr_d   = cfg_ctr_i;
          isr_d   = cfg_isr_i;
          cnt_d   = '0;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (tx_idle_i && rx_idle_i) begin
          state_d = ST_WR_LDVR;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          // Saturating increment; the CNT_LAST exit normally fires first.
          cnt_d = cnt_q + 1'b1;
        end
      end
      // After LDVR the writes are unconditional. This keeps LDVR and UDVR
      // in adjacent cycles, which the register file needs in order to
      // commit the divisor.
      ST_WR_LDVR: state_d = ST_WR_UDVR;
      ST_WR_UDVR: state_d = ST_WR_STR;
      ST_WR_STR:  state_d = ST_WR_FSR;
      ST_WR_FSR:  state_d = ST_WR_CTR;
      ST_WR_CTR:  state_d = ST_WR_ISR;
      ST_WR_ISR:  state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      str_q     <= '0;
      fsr_q     <= '0;
      ctr_q     <= '0;
      isr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      str_q     <= str_d;
      fsr_q     <= fsr_d;
      ctr_q     <= ctr_d;
      isr_q     <= isr_d;
      timeout_q <= timeout_d;
    end
  end

  // Bus mux and status
  // Non-write busy states (WAIT_IDLE, DONE) park the bus on STR_ADDR with
  // zero data. An LDVR->UDVR address pair can then only come from the write
  // states themselves.
  always_comb begin
    bus_read_o    = 1'b0;
    bus_write_o   = 1'b0;
    bus_address_o = STR_ADDR;
    bus_data_o    = '0;
    busy_o        = 1'b1;
    cpu_wait_o    = cpu_read_i | cpu_write_i;

    case (state_q)
      ST_IDLE: begin
        bus_read_o    = cpu_read_i;
        bus_write_o   = cpu_write_i;
        bus_address_o = cpu_address_i;
        bus_data_o    = cpu_data_i;
        busy_o        = 1'b0;
        cpu_wait_o    = 1'b0;
      end
      ST_WR_LDVR: begin
        bus_write_o   = 1'b1;
        bus_address_o = LDVR_ADDR;
        bus_data_o    = div_q[7:0];
      end
      ST_WR_UDVR: begin
        bus_write_o   = 1'b1;
        bus_address_o = UDVR_ADDR;
        bus_data_o    = div_q[15:8];
      end
      ST_WR_STR: begin
        bus_write_o   = 1'b1;
        bus_address_o = STR_ADDR;
        bus_data_o    = str_q;
      end
      ST_WR_FSR: begin
        bus_write_o   = 1'b1;
        bus_address_o = FSR_ADDR;
        bus_data_o    = fsr_q;
      end
      ST_WR_CTR: begin
        bus_write_o   = 1'b1;
        bus_address_o = CTR_ADDR;
        bus_data_o    = ctr_q;
      end
      ST_WR_ISR: begin
        bus_write_o   = 1'b1;
        bus_address_o = ISR_ADDR;
        bus_data_o    = isr_q;
      end
      default: begin
        // WAIT_IDLE and DONE keep the parked defaults.
      end
    endcase
  end

  assign done_o    = (state_q == ST_DONE);
  // Registered: the pulse appears in the first IDLE cycle after the wait
  // expires.
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_config_bus_sequencer.sv
module tb_config_bus_sequencer;
  import registers_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] cfg_divisor_i = '0;
  logic [7:0]  cfg_str_i = '0;
  logic [7:0]  cfg_fsr_i = '0;
  logic [7:0]  cfg_ctr_i = '0;
  logic [7:0]  cfg_isr_i = '0;
  logic        tx_idle_i = 1'b1;
  logic        rx_idle_i = 1'b1;
  logic        cpu_read_i = 1'b0;
  logic        cpu_write_i = 1'b0;
  logic [2:0]  cpu_address_i = '0;
  logic [7:0]  cpu_data_i = '0;
  logic        cpu_wait_o;
  logic        bus_read_o;
  logic        bus_write_o;
  logic [2:0]  bus_address_o;
  logic [7:0]  bus_data_o;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;

  config_bus_sequencer #(.IDLE_TIMEOUT(TO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .cfg_divisor_i (cfg_divisor_i),
    .cfg_str_i     (cfg_str_i),
    .cfg_fsr_i     (cfg_fsr_i),
    .cfg_ctr_i     (cfg_ctr_i),
    .cfg_isr_i     (cfg_isr_i),
    .tx_idle_i     (tx_idle_i),
    .rx_idle_i     (rx_idle_i),
    .cpu_read_i    (cpu_read_i),
    .cpu_write_i   (cpu_write_i),
    .cpu_address_i (cpu_address_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_wait_o    (cpu_wait_o),
    .bus_read_o    (bus_read_o),
    .bus_write_o   (bus_write_o),
    .bus_address_o (bus_address_o),
    .bus_data_o    (bus_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];   // expected sequencer writes: {addr, data}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_cfg();
    cfg_divisor_i = 16'($urandom);
    cfg_str_i     = 8'($urandom);
    cfg_fsr_i     = 8'($urandom);
    cfg_ctr_i     = 8'($urandom);
    cfg_isr_i     = 8'($urandom);
  endtask

  // One configuration request. Called at posedge+1, and the current cycle
  // becomes the start cycle s.
  //   low       : link not idle in cycles s..s+low-1, idle from s+low
  //               (it goes random once the writes are committed)
  //   cpu window: [base+cpu_a, base+cpu_b], base = w (idle seen) or s
  //   rst_off   : reset in cycle w+rst_off (-1 = none)
  // Reference: the first WAIT_IDLE cycle (s+1..s+TO) with the link idle is
  // w. The writes fall in w+1..w+6 and done in w+7. If there is no such
  // cycle, the sequencer is busy through s+TO and timeout pulses at
  // s+TO+1.
  task automatic run_seq(input int low, input bit cpu_rel_w, input int cpu_a,
                         input int cpu_b, input bit cpu_is_wr, input int rst_off,
                         input bit fixed_cfg);
    int s, w, rc, busy_end, cfrom, cto, last, base;
    bit strobe, busy_e, wr_e, done_e, to_e;
    logic [2:0]  caddr;
    logic [7:0]  cdata;
    logic [10:0] item;
    logic [10:0] table_w[6];
    if (!fixed_cfg) rand_cfg();
    s = cyc;
    w = -1;
    for (int k = 1; k <= TO; k++) begin
      if (w < 0 && k >= low) w = s + k;
    end
    busy_end = (w >= 0) ? w + 7 : s + TO;
    rc = (rst_off >= 0 && w >= 0) ? w + rst_off : -1;
    if (rc >= 0) busy_end = rc;
    table_w[0] = {LDVR_ADDR, cfg_divisor_i[7:0]};
    table_w[1] = {UDVR_ADDR, cfg_divisor_i[15:8]};
    table_w[2] = {STR_ADDR, cfg_str_i};
    table_w[3] = {FSR_ADDR, cfg_fsr_i};
    table_w[4] = {CTR_ADDR, cfg_ctr_i};
    table_w[5] = {ISR_ADDR, cfg_isr_i};
    exp_q.delete();
    if (w >= 0)
      for (int i = 0; i < 6; i++)
        if (rc < 0 || w + 1 + i <= rc) exp_q.push_back(table_w[i]);
    base = cpu_rel_w ? ((w >= 0) ? w : s) : s;
    cfrom = base + cpu_a;
    cto   = base + cpu_b;
    caddr = 3'($urandom);
    cdata = 8'($urandom);
    last = ((w >= 0) ? w + 7 : s + TO + 1);
    if (rc >= 0) last = rc;
    if (cto > last) last = cto;
    last = last + 2;

    for (int c = s; c <= last; c++) begin
      start_i = (c == s);
      rst_i = (c == rc);
      if (c > s) rand_cfg();   // the sequencer must use the captured set
      if (w >= 0 && c > w) begin
        tx_idle_i = 1'($urandom_range(0, 1));
        rx_idle_i = 1'($urandom_range(0, 1));
      end else if (c - s >= low) begin
        tx_idle_i = 1'b1;
        rx_idle_i = 1'b1;
      end else begin
        tx_idle_i = 1'b0;
        rx_idle_i = 1'($urandom_range(0, 1));
      end
      strobe = (c >= cfrom && c <= cto);
      cpu_write_i = strobe && cpu_is_wr;
      cpu_read_i  = strobe && !cpu_is_wr;
      cpu_address_i = caddr;
      cpu_data_i = cdata;

      @(negedge clk_i);
      busy_e = (c > s && c <= busy_end);
      wr_e   = (w >= 0 && c > w && c <= w + 6 && (rc < 0 || c <= rc));
      done_e = (w >= 0 && c == w + 7 && rc < 0);
      to_e   = (w < 0 && c == s + TO + 1);
      chk($sformatf("busy c%0d", c - s), busy_o, busy_e);
      chk($sformatf("done c%0d", c - s), done_o, done_e);
      chk($sformatf("timeout c%0d", c - s), timeout_o, to_e);
      chk($sformatf("cpu_wait c%0d", c - s), cpu_wait_o, busy_e && strobe);
      if (busy_e) begin
        chk($sformatf("bus_write c%0d", c - s), bus_write_o, wr_e);
        chk($sformatf("bus_read c%0d", c - s), bus_read_o, 1'b0);
        if (wr_e) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("exp_q empty c%0d", c - s), 1'b1, 1'b0);
          end else begin
            item = exp_q.pop_front();
            chk($sformatf("wr addr/data c%0d", c - s), {bus_address_o, bus_data_o}, item);
          end
        end else begin
          chk($sformatf("park c%0d", c - s), {bus_address_o, bus_data_o}, {STR_ADDR, 8'h00});
        end
      end else begin
        chk($sformatf("mirror c%0d", c - s),
            {bus_read_o, bus_write_o, bus_address_o, bus_data_o},
            {strobe && !cpu_is_wr, strobe && cpu_is_wr, caddr, cdata});
      end
      step();
    end
    start_i = 1'b0;
    rst_i = 1'b0;
    cpu_read_i = 1'b0;
    cpu_write_i = 1'b0;
    tx_idle_i = 1'b1;
    rx_idle_i = 1'b1;
    chk("exp_q drained", exp_q.size(), 0);
  endtask

  // ---------------- directed steps ----------------
  initial begin
    // Reset with a host strobe present: IDLE still mirrors the host, with
    // no wait.
    cpu_write_i = 1'b1;
    cpu_address_i = 3'd6;
    cpu_data_i = 8'hA5;
    step();
    step();
    @(negedge clk_i);
    chk("rst busy", busy_o, 1'b0);
    chk("rst done", done_o, 1'b0);
    chk("rst timeout", timeout_o, 1'b0);
    chk("rst cpu_wait", cpu_wait_o, 1'b0);
    rst_i = 1'b0;
    step();

    // IDLE pass-through of random host accesses.
    for (int i = 0; i < 6; i++) begin
      cpu_read_i = 1'($urandom_range(0, 1));
      cpu_write_i = 1'($urandom_range(0, 1));
      cpu_address_i = 3'($urandom);
      cpu_data_i = 8'($urandom);
      @(negedge clk_i);
      chk("idle mirror", {bus_read_o, bus_write_o, bus_address_o, bus_data_o},
          {cpu_read_i, cpu_write_i, cpu_address_i, cpu_data_i});
      chk("idle busy", busy_o, 1'b0);
      chk("idle cpu_wait", cpu_wait_o, 1'b0);
      step();
    end
    cpu_read_i = 1'b0;
    cpu_write_i = 1'b0;
    step();

    // Reference vector on an idle link.
    cfg_divisor_i = 16'h1A2B;
    cfg_str_i = 8'h15;
    cfg_fsr_i = 8'h08;
    cfg_ctr_i = 8'h28;
    cfg_isr_i = 8'hF0;
    run_seq(0, 1'b0, 0, -1, 1'b1, -1, 1'b1);
    step();
    // Link busy for 5 cycles after start.
    run_seq(5, 1'b0, 0, -1, 1'b1, -1, 1'b0);
    step();
    // Start together with a host write: the write passes in the start cycle.
    run_seq(0, 1'b0, 0, 0, 1'b1, -1, 1'b0);
    step();
    // Host write from WR_STR until back in IDLE: blocked, then forwarded.
    run_seq(2, 1'b1, 3, 8, 1'b1, -1, 1'b0);
    step();
    // Host read across WAIT_IDLE.
    run_seq(3, 1'b0, 0, 3, 1'b0, -1, 1'b0);
    step();
    // Link never idle: timeout without bus writes.
    run_seq(1000, 1'b0, 0, -1, 1'b1, -1, 1'b0);
    step();
    // Timeout boundary: idle exactly in the last WAIT_IDLE cycle.
    run_seq(TO, 1'b0, 0, -1, 1'b1, -1, 1'b0);
    step();
    // Reset during WR_FSR, then a complete run.
    run_seq(1, 1'b0, 0, -1, 1'b1, 4, 1'b0);
    step();
    run_seq(0, 1'b0, 0, -1, 1'b1, -1, 1'b0);
    step();
    // Random mix.
    for (int i = 0; i < 8; i++) begin
      run_seq($urandom_range(0, TO + 4), 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), $urandom_range(0, 9),
              1'($urandom_range(0, 1)), -1, 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
